// File: rtl/seg_display_scan_pkg.sv
// seg_pkg: shared types and constants for the six-digit seven-segment scanner.
// Segment codes are logical (1 = segment lit), ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  // Number of digits on the display: h2 h1 : m2 m1 : s2 s1
  localparam int NUM_DIGITS = 6;

  typedef logic [2:0] digit_idx_t;
  typedef logic [3:0] bcd_t;

  // Slot numbers of interest; slot 0 is the rightmost digit (seconds units)
  localparam digit_idx_t LAST_IDX    = digit_idx_t'(NUM_DIGITS - 1);
  localparam digit_idx_t DP_SLOT_SEC = 3'd2;
  localparam digit_idx_t DP_SLOT_MIN = 3'd4;
  localparam digit_idx_t FIRST_BLINK = 3'd2;

  // All segments dark
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Decode table, element [n] holds the pattern for digit n
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  // Snapshot of the six displayed digits, index 0 = s1 ... index 5 = h2
  typedef bcd_t snap_t [NUM_DIGITS];

  // True when the code is a legal decimal digit
  function automatic logic is_decimal(input bcd_t d);
    return (d <= 4'd9);
  endfunction

  // Separators sit after the seconds pair and after the minutes pair
  function automatic logic is_dp_slot(input digit_idx_t idx);
    return (idx == DP_SLOT_SEC) || (idx == DP_SLOT_MIN);
  endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// seg_display_scan_if: digit inputs from the clock counter plus the
// multiplexed display drive. The master is the producer of the time digits
// and the consumer of the display lines; the slave is the scanner itself.
interface seg_display_scan_if;
  import seg_pkg::*;

  bcd_t s1;
  bcd_t s2;
  bcd_t m1;
  bcd_t m2;
  bcd_t h1;
  bcd_t h2;
  logic key;
  logic blank_lz;

  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;

  modport master (
    output s1, s2, m1, m2, h1, h2, key, blank_lz,
    input  an, seg, dp
  );

  modport slave (
    input  s1, s2, m1, m2, h1, h2, key, blank_lz,
    output an, seg, dp
  );

endinterface

// File: rtl/seg_display_scan_bcd_to_seg.sv
// bcd_to_seg: purely combinational BCD to seven-segment decoder.
// Codes 10..15 produce a dark digit rather than a garbage pattern.
module bcd_to_seg
  import seg_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);

  // Table lookup for legal digits, blank for anything above nine
  always_comb begin
    seg = SEG_BLANK;
    if (is_decimal(digit)) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/seg_display_scan.sv
// seg_display_scan: time-multiplexes six BCD digits onto one seven-segment
// display. A prescaler produces a scan tick every SCAN_DIV clocks, the digit
// index steps on each tick, and the six inputs are snapshotted when the index
// wraps so a frame never mixes old and new time values. Outputs are registered.
// Optional feature: define SEG_BLINK_EN to blink minutes/hours in set mode.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 250,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  seg_display_scan_if.slave  bus
);

  // Counter widths; a divide-by-one still needs a one-bit register
  localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  // XOR masks that turn logical levels into pin levels; also the idle level
  localparam logic [NUM_DIGITS-1:0] AN_POL  = ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]            SEG_POL = ACTIVE_LOW ? '1 : '0;
  localparam logic                  DP_POL  = ACTIVE_LOW;

  logic [PW-1:0] pre_cnt;
  logic          tick;
  digit_idx_t    idx;
  logic          wrap;
  snap_t         snap;

  bcd_t       cur_digit;
  logic [6:0] dec_seg;
  logic       lz_blank;
  logic       mode_blank;

  logic [NUM_DIGITS-1:0] nxt_an;
  logic [6:0]            nxt_seg;
  logic                  nxt_dp;

  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;

  assign tick = (pre_cnt == PRE_LAST);
  assign wrap = tick && (idx == LAST_IDX);

  // Prescaler: free-running 0..SCAN_DIV-1, one tick per digit slot
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Digit index: steps on every tick and wraps from the last slot to slot 0
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (tick) begin
      if (idx == LAST_IDX) begin
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Snapshot: capture all six digits on the frame boundary only
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        snap[i] <= '0;
      end
    end else if (wrap) begin
      snap[0] <= bus.s1;
      snap[1] <= bus.s2;
      snap[2] <= bus.m1;
      snap[3] <= bus.m2;
      snap[4] <= bus.h1;
      snap[5] <= bus.h2;
    end
  end

`ifdef SEG_BLINK_EN
  logic [BW-1:0] blink_cnt;
  logic          phase_on;

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // Blink timer: counts scan ticks regardless of mode, toggles phase on wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // In set mode the minutes and hours digits go dark during the off phase
  always_comb begin
    mode_blank = 1'b0;
    if (!bus.key && !phase_on && (idx >= FIRST_BLINK)) begin
      mode_blank = 1'b1;
    end
  end
`else
  // Without blinking the mode key has no effect on the display
  always_comb begin
    mode_blank = 1'b0;
  end
`endif

  // Select the snapshot digit for the slot currently being scanned
  always_comb begin
    cur_digit = '0;
    case (idx)
      3'd0:    cur_digit = snap[0];
      3'd1:    cur_digit = snap[1];
      3'd2:    cur_digit = snap[2];
      3'd3:    cur_digit = snap[3];
      3'd4:    cur_digit = snap[4];
      3'd5:    cur_digit = snap[5];
      default: cur_digit = '0;
    endcase
  end

  bcd_to_seg u_dec (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  // Logical next-output values: anode one-hot, segments with blanking, separators
  always_comb begin
    lz_blank = bus.blank_lz && (idx == LAST_IDX) && (snap[5] == 4'd0);
    nxt_an   = NUM_DIGITS'(1) << idx;
    nxt_dp   = is_dp_slot(idx);
    nxt_seg  = dec_seg;
    if (lz_blank || mode_blank) begin
      nxt_seg = SEG_BLANK;
    end
  end

  // Output registers with board polarity applied last; reset drives idle levels
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= AN_POL;
      seg_q <= SEG_POL;
      dp_q  <= DP_POL;
    end else begin
      an_q  <= nxt_an ^ AN_POL;
      seg_q <= nxt_seg ^ SEG_POL;
      dp_q  <= nxt_dp ^ DP_POL;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan: directed bench for seg_display_scan with SCAN_DIV=4,
// BLINK_DIV=2. Two instances share the stimulus, one active-high and one
// active-low; the active-low one is expected to show the bitwise inverse.
// Blink expectations follow SEG_BLINK_EN.
module tb_seg_display_scan;
  import seg_pkg::*;

`ifdef SEG_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  bcd_t s1, s2, m1, m2, h1, h2;
  logic key;
  logic blank_lz;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  seg_display_scan_if bus0 ();
  seg_display_scan_if bus1 ();

  assign bus0.s1 = s1;
  assign bus0.s2 = s2;
  assign bus0.m1 = m1;
  assign bus0.m2 = m2;
  assign bus0.h1 = h1;
  assign bus0.h2 = h2;
  assign bus0.key = key;
  assign bus0.blank_lz = blank_lz;
  assign bus1.s1 = s1;
  assign bus1.s2 = s2;
  assign bus1.m1 = m1;
  assign bus1.m2 = m2;
  assign bus1.h1 = h1;
  assign bus1.h2 = h2;
  assign bus1.key = key;
  assign bus1.blank_lz = blank_lz;

  seg_display_scan #(.SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  seg_display_scan #(.SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // 10 ns board clock
  always #5 clk = ~clk;

  // Drive the six digits as hh:mm:ss in one call
  task automatic applyStimulus(input bcd_t th2, input bcd_t th1, input bcd_t tm2,
                               input bcd_t tm1, input bcd_t ts2, input bcd_t ts1);
    h2 = th2; h1 = th1; m2 = tm2; m1 = tm1; s2 = ts2; s1 = ts1;
  endtask

  // Advance to the falling edge that follows rising edge k after reset release
  task automatic waitEdge(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Compare both instances against the logical expectation
  task automatic checkOutput(input string tag, input logic [5:0] ean,
                             input logic [6:0] eseg, input logic edp);
    tests++;
    assert (bus0.an === ean) else begin
      fails++;
      $error("[TB] FAIL %s an: got %b expected %b", tag, bus0.an, ean);
    end
    tests++;
    assert (bus0.seg === eseg) else begin
      fails++;
      $error("[TB] FAIL %s seg: got %h expected %h", tag, bus0.seg, eseg);
    end
    tests++;
    assert (bus0.dp === edp) else begin
      fails++;
      $error("[TB] FAIL %s dp: got %b expected %b", tag, bus0.dp, edp);
    end
    tests++;
    assert ({bus1.an, bus1.seg, bus1.dp} === ~{ean, eseg, edp}) else begin
      fails++;
      $error("[TB] FAIL %s active_low: got %b expected %b", tag,
             {bus1.an, bus1.seg, bus1.dp}, ~{ean, eseg, edp});
    end
  endtask

  // Exactly one anode enabled on the active-high instance
  task automatic checkOneHot(input string tag);
    tests++;
    assert ($onehot(bus0.an)) else begin
      fails++;
      $error("[TB] FAIL %s onehot: got %b expected one bit set", tag, bus0.an);
    end
  endtask

  // Hold reset for n cycles, then release at a falling edge and restart the edge count
  task automatic doReset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    checkOutput("reset", 6'b000000, 7'h00, 1'b0);
    reset = 1'b0;
    cyc = 0;
  endtask

  // Directed sequence; edge k shows slot floor((k-1)/4) mod 6, frames wrap every 24 edges
  initial begin
    reset = 1'b1;
    key = 1'b1;
    blank_lz = 1'b0;
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

    // Test 1: reset and first slot
    @(negedge clk);
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    doReset(3);
    waitEdge(1);
    checkOutput("first_slot", 6'b000001, 7'h3F, 1'b0);
    waitEdge(4);
    checkOutput("after_first_tick", 6'b000001, 7'h3F, 1'b0);
    waitEdge(5);
    checkOutput("slot1_frame0", 6'b000010, 7'h3F, 1'b0);

    // Test 2: 12:34:56 in the first full frame, each slot exactly 4 clocks
    waitEdge(24);
    checkOutput("frame0_slot5_end", 6'b100000, 7'h3F, 1'b0);
    for (int k = 25; k <= 48; k++) begin
      waitEdge(k);
      checkOneHot("frame1");
    end
    cyc = 24;
    waitEdge(25); checkOutput("f1_s0_first", 6'b000001, 7'h7D, 1'b0);
    waitEdge(28); checkOutput("f1_s0_last",  6'b000001, 7'h7D, 1'b0);
    waitEdge(29); checkOutput("f1_s1_first", 6'b000010, 7'h6D, 1'b0);
    waitEdge(33); checkOutput("f1_s2_first", 6'b000100, 7'h66, 1'b1);
    waitEdge(37); checkOutput("f1_s3_first", 6'b001000, 7'h4F, 1'b0);
    waitEdge(41); checkOutput("f1_s4_first", 6'b010000, 7'h5B, 1'b1);
    waitEdge(45); checkOutput("f1_s5_first", 6'b100000, 7'h06, 1'b0);
    waitEdge(48); checkOutput("f1_s5_last",  6'b100000, 7'h06, 1'b0);

    // Test 3: s1 changes mid-frame, visible only from the next frame
    waitEdge(50); checkOutput("f2_s0_old", 6'b000001, 7'h7D, 1'b0);
    waitEdge(62); checkOutput("f2_s3", 6'b001000, 7'h4F, 1'b0);
    s1 = 4'd9;
    waitEdge(72); checkOutput("f2_s5_end", 6'b100000, 7'h06, 1'b0);
    waitEdge(73); checkOutput("f3_s0_new", 6'b000001, 7'h6F, 1'b0);

    // Test 4: leading-zero blanking of the hours tens digit
    waitEdge(74);
    h2 = 4'd0;
    h1 = 4'd7;
    blank_lz = 1'b1;
    waitEdge(114); checkOutput("f4_s4_h1", 6'b010000, 7'h07, 1'b1);
    waitEdge(118); checkOutput("f4_s5_lz", 6'b100000, 7'h00, 1'b0);
    waitEdge(121);
    blank_lz = 1'b0;
    s1 = 4'hC;
    waitEdge(142); checkOutput("f5_s5_zero", 6'b100000, 7'h3F, 1'b0);

    // Test 5: non-decimal code blanks, mid-slot reset idles outputs next clock
    waitEdge(146); checkOutput("f6_s0_hexC", 6'b000001, 7'h00, 1'b0);
    waitEdge(158); checkOutput("f6_s3", 6'b001000, 7'h4F, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid_slot", 6'b000000, 7'h00, 1'b0);

    // Test 6: set mode; minutes/hours blink only when the blink feature is built in
    key = 1'b0;
    blank_lz = 1'b0;
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    doReset(2);
    waitEdge(26); checkOutput("blink_s0_lit", 6'b000001, 7'h7D, 1'b0);
    waitEdge(34); checkOutput("blink_s2_on",  6'b000100, 7'h66, 1'b1);
    waitEdge(42); checkOutput("blink_s4_off", 6'b010000, BLINK ? 7'h00 : 7'h5B, 1'b1);
    waitEdge(46); checkOutput("blink_s5_off", 6'b100000, BLINK ? 7'h00 : 7'h06, 1'b0);
    waitEdge(58); checkOutput("blink_s2_off", 6'b000100, BLINK ? 7'h00 : 7'h66, 1'b1);
    waitEdge(66); checkOutput("blink_s4_on",  6'b010000, 7'h5B, 1'b1);
    key = 1'b1;
    waitEdge(90); checkOutput("run_s4_lit", 6'b010000, 7'h5B, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
